// File: rtl/way_select_plru_if.sv
// rtl/way_select_plru_if.sv - lookup/update bus between the cache control path and the PLRU selector
interface way_select_plru_if #(
  parameter int WAYS = 4,
  parameter int SETS = 256
);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic             clr;
  logic [SET_W-1:0] rd_set;
  logic [WAYS-1:0]  way_valid;
  logic [WAYS-1:0]  victim_oh;
  logic [WAY_W-1:0] victim_idx;
  logic             upd_en;
  logic [SET_W-1:0] upd_set;
  logic [WAYS-1:0]  upd_way;

  modport master (
    output clr, rd_set, way_valid, upd_en, upd_set, upd_way,
    input  victim_oh, victim_idx
  );

  modport slave (
    input  clr, rd_set, way_valid, upd_en, upd_set, upd_way,
    output victim_oh, victim_idx
  );
endinterface

// File: rtl/way_select_plru.sv
// rtl/way_select_plru.sv - per-set tree pseudo-LRU victim selector for a WAYS-way, SETS-set cache
// Optional feature macro: PLRU_INVALID_FIRST_EN (pick the lowest invalid way before consulting the tree)
module way_select_plru #(
  parameter int WAYS = 4,
  parameter int SETS = 256
) (
  input  logic              clk,
  input  logic              rst,
  way_select_plru_if.slave  bus
);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  // Heap node k is stored at bit k+1, so a node's children are {n,0} and {n,1}
  logic [WAYS-1:1]  tree_q [SETS];

  logic [WAYS-1:1]  rd_tree;
  logic [WAYS-1:1]  upd_tree;
  logic [WAYS-1:1]  upd_next;
  logic [WAY_W:0]   walk;
  logic [WAY_W:0]   upd_node;
  logic [WAY_W-1:0] upd_path;
  logic [WAY_W-1:0] upd_idx;
  logic [WAY_W-1:0] tree_idx;
  logic [WAY_W-1:0] victim_idx;
  logic             upd_any;
  logic             upd_bit;

  assign rd_tree  = tree_q[bus.rd_set];
  assign upd_tree = tree_q[bus.upd_set];
  assign upd_any  = |bus.upd_way;

  always_comb begin
    walk = (WAY_W+1)'(1);
    for (int l = 0; l < WAY_W; l++) begin
      walk = {walk[WAY_W-1:0], rd_tree[walk[WAY_W-1:0]]};
    end
    tree_idx = walk[WAY_W-1:0];
  end

  // Lowest set bit of upd_way wins; scanning downward lets it overwrite higher ones
  always_comb begin
    upd_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (bus.upd_way[w]) begin
        upd_idx = WAY_W'(w);
      end
    end
  end

  always_comb begin
    upd_next = upd_tree;
    upd_node = (WAY_W+1)'(1);
    upd_path = upd_idx;
    upd_bit  = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      upd_bit                      = upd_path[WAY_W-1];
      upd_next[upd_node[WAY_W-1:0]] = ~upd_bit;
      upd_node                     = {upd_node[WAY_W-1:0], upd_bit};
      upd_path                     = upd_path << 1;
    end
  end

`ifdef PLRU_INVALID_FIRST_EN
  always_comb begin
    victim_idx = tree_idx;
    if (!(&bus.way_valid)) begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (!bus.way_valid[w]) begin
          victim_idx = WAY_W'(w);
        end
      end
    end
  end
`else
  assign victim_idx = tree_idx;
`endif

  assign bus.victim_idx = victim_idx;
  assign bus.victim_oh  = WAYS'(1) << victim_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        tree_q[s] <= '0;
      end
    end else if (bus.clr) begin
      for (int s = 0; s < SETS; s++) begin
        tree_q[s] <= '0;
      end
    end else if (bus.upd_en && upd_any) begin
      tree_q[bus.upd_set] <= upd_next;
    end
  end
endmodule

// File: tb/tb_way_select_plru.sv
// tb/tb_way_select_plru.sv - scoreboard bench for way_select_plru (honours PLRU_INVALID_FIRST_EN)
module tb_way_select_plru;
  localparam int WAYS  = 4;
  localparam int SETS  = 256;
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  way_select_plru_if #(.WAYS(WAYS), .SETS(SETS)) bus ();
  way_select_plru #(.WAYS(WAYS), .SETS(SETS)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference tree, 0-based heap: children of n are 2n+1 and 2n+2
  logic m [SETS][WAYS-1];
  int   sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_idx;

  function automatic int model_victim(int set, logic [WAYS-1:0] valid);
    int node;
    node = 0;
`ifdef PLRU_INVALID_FIRST_EN
    for (int w = 0; w < WAYS; w++) if (!valid[w]) return w;
`else
    if (valid === 'x) node = 0;
`endif
    while (node < WAYS - 1) node = 2 * node + 1 + int'(m[set][node]);
    return node - (WAYS - 1);
  endfunction

  function automatic void model_update(int set, logic [WAYS-1:0] way);
    int w, leaf, parent;
    w = -1;
    for (int i = WAYS - 1; i >= 0; i--) if (way[i]) w = i;
    if (w < 0) return;
    leaf = WAYS - 1 + w;
    while (leaf > 0) begin
      parent = (leaf - 1) / 2;
      m[set][parent] = (leaf == 2 * parent + 1);
      leaf = parent;
    end
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int n = 0; n < WAYS - 1; n++) m[s][n] = 1'b0;
  endfunction

  task automatic update(int set, logic [WAYS-1:0] way);
    @(negedge clk);
    bus.upd_en  = 1'b1;
    bus.upd_set = SET_W'(set);
    bus.upd_way = way;
    @(posedge clk);
    model_update(set, way);
    #1 bus.upd_en = 1'b0;
  endtask

  task automatic look(int set);
    bus.rd_set = SET_W'(set);
    sb.push_back(model_victim(set, bus.way_valid));
    #1;
  endtask

  task automatic test_reset();
    int sets_t[2];
    sets_t = '{0, 255};
    bus.clr = 0; bus.upd_en = 0; bus.upd_set = '0; bus.upd_way = '0;
    bus.rd_set = '0; bus.way_valid = '1;
    rst = 1'b1;
    model_clear();
    #12;
    foreach (sets_t[i]) begin
      look(sets_t[i]);
      exp_idx = sb.pop_front(); vectors++;
      if (bus.victim_idx !== WAY_W'(exp_idx) || bus.victim_oh !== (WAYS'(1) << exp_idx)) begin
        miscompares++;
        $display("FAIL reset set=%0d: idx=%0d oh=%b required idx=%0d", sets_t[i], bus.victim_idx, bus.victim_oh, exp_idx);
      end
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_sequence();
    for (int w = 0; w < WAYS; w++) begin
      update(5, WAYS'(1) << w);
      look(5);
      exp_idx = sb.pop_front(); vectors++;
      if (bus.victim_idx !== WAY_W'(exp_idx) || bus.victim_oh !== (WAYS'(1) << exp_idx)) begin
        miscompares++;
        $display("FAIL sequence way=%0d: idx=%0d oh=%b required idx=%0d", w, bus.victim_idx, bus.victim_oh, exp_idx);
      end
    end
  endtask

  task automatic test_isolation();
    look(6);
    exp_idx = sb.pop_front(); vectors++;
    if (bus.victim_idx !== WAY_W'(exp_idx) || bus.victim_oh !== (WAYS'(1) << exp_idx)) begin
      miscompares++;
      $display("FAIL isolation set=6: idx=%0d required idx=%0d", bus.victim_idx, exp_idx);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    bus.upd_en = 1'b1; bus.upd_set = SET_W'(9); bus.upd_way = 4'b0001;
    look(9);
    exp_idx = sb.pop_front(); vectors++;
    if (bus.victim_idx !== WAY_W'(exp_idx)) begin
      miscompares++;
      $display("FAIL same_cycle pre: idx=%0d required idx=%0d", bus.victim_idx, exp_idx);
    end
    @(posedge clk);
    model_update(9, 4'b0001);
    #1 bus.upd_en = 1'b0;
    look(9);
    exp_idx = sb.pop_front(); vectors++;
    if (bus.victim_idx !== WAY_W'(exp_idx) || exp_idx != 2) begin
      miscompares++;
      $display("FAIL same_cycle post: idx=%0d required idx=%0d", bus.victim_idx, exp_idx);
    end
  endtask

  task automatic test_malformed();
    logic [WAYS-1:0] ways_t[3];
    ways_t = '{4'b0000, 4'b0110, 4'b1100};
    foreach (ways_t[i]) begin
      update(10, ways_t[i]);
      look(10);
      exp_idx = sb.pop_front(); vectors++;
      if (bus.victim_idx !== WAY_W'(exp_idx)) begin
        miscompares++;
        $display("FAIL malformed upd_way=%b: idx=%0d required idx=%0d", ways_t[i], bus.victim_idx, exp_idx);
      end
    end
  endtask

  task automatic test_invalid_first();
    logic [WAYS-1:0] valid_t[4];
    valid_t = '{4'b1101, 4'b1111, 4'b0000, 4'b0111};
    update(20, 4'b0001);
    foreach (valid_t[i]) begin
      bus.way_valid = valid_t[i];
      look(20);
      exp_idx = sb.pop_front(); vectors++;
      if (bus.victim_idx !== WAY_W'(exp_idx) || bus.victim_oh !== (WAYS'(1) << exp_idx)) begin
        miscompares++;
        $display("FAIL invalid_first valid=%b: idx=%0d required idx=%0d", valid_t[i], bus.victim_idx, exp_idx);
      end
    end
    bus.way_valid = '1;
  endtask

  task automatic test_clr();
    int sets_t[3];
    sets_t = '{5, 9, 10};
    @(negedge clk);
    bus.clr = 1'b1; bus.upd_en = 1'b1; bus.upd_set = SET_W'(5); bus.upd_way = 4'b0100;
    @(posedge clk);
    model_clear();
    #1 bus.clr = 1'b0; bus.upd_en = 1'b0;
    foreach (sets_t[i]) begin
      look(sets_t[i]);
      exp_idx = sb.pop_front(); vectors++;
      if (bus.victim_idx !== WAY_W'(exp_idx)) begin
        miscompares++;
        $display("FAIL clr set=%0d: idx=%0d required idx=%0d", sets_t[i], bus.victim_idx, exp_idx);
      end
    end
  endtask

  task automatic test_async_reset();
    update(5, 4'b0001);
    update(5, 4'b0100);
    look(5);
    exp_idx = sb.pop_front(); vectors++;
    if (bus.victim_idx !== WAY_W'(exp_idx)) begin
      miscompares++;
      $display("FAIL async_reset pre: idx=%0d required idx=%0d", bus.victim_idx, exp_idx);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    model_clear();
    look(5);
    exp_idx = sb.pop_front(); vectors++;
    if (bus.victim_idx !== WAY_W'(exp_idx)) begin
      miscompares++;
      $display("FAIL async_reset no-edge: idx=%0d required idx=%0d", bus.victim_idx, exp_idx);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) update($urandom_range(0, 7), WAYS'($urandom_range(0, 15)));
      else update($urandom_range(0, 7), WAYS'(1) << $urandom_range(0, WAYS - 1));
      look($urandom_range(0, 7));
      exp_idx = sb.pop_front(); vectors++;
      if (bus.victim_idx !== WAY_W'(exp_idx) || bus.victim_oh !== (WAYS'(1) << exp_idx)) begin
        miscompares++;
        $display("FAIL random iter=%0d set=%0d: idx=%0d oh=%b required idx=%0d", i, bus.rd_set, bus.victim_idx, bus.victim_oh, exp_idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_isolation();
    test_same_cycle();
    test_malformed();
    test_invalid_first();
    test_clr();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
